multi_seq_nbit: RTL

Parametrised sequential unsigned multiplier, the clocked successor to the team's combinational 16-bit shift-add multiplier.
- Consumes RADIX_BITS multiplier bits per cycle.
- Trades latency for area.
- Wraps operands and result in valid/ready handshakes so it can sit directly in a streaming datapath.

---
 rtl/multi_seq_nbit.sv | 111 +++++++++++
 1 files changed

// File: rtl/multi_seq_nbit.sv
// Sequential shift-add unsigned multiplier, RADIX_BITS multiplier bits per RUN cycle, valid/ready on both sides.
// Optional MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module multi_seq_nbit #(
  parameter int WIDTH      = 16,
  parameter int RADIX_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int STEPS = WIDTH / RADIX_BITS;
  localparam int SW    = $clog2(STEPS + 1);
  localparam int PW    = 2 * WIDTH;

  generate
    if (WIDTH < 2 || RADIX_BITS < 1 || (WIDTH % RADIX_BITS) != 0) begin : g_bad_param
      $error("multi_seq_nbit: RADIX_BITS must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  // state | meaning: IDLE accept operands | RUN shift-add one chunk per edge | DONE hold product until taken
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   a_sh_q, a_sh_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   product_q, product_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [SW-1:0]   step_q, step_d;
  logic [PW-1:0]   chunk;
  logic [PW-1:0]   acc_sum;
  logic [WIDTH-1:0] b_next;
  logic            last_step;

  always_comb begin
    chunk                   = '0;
    chunk[RADIX_BITS-1:0]   = b_sh_q[RADIX_BITS-1:0];
    acc_sum                 = acc_q + a_sh_q * chunk;
    b_next                  = b_sh_q >> RADIX_BITS;
`ifdef MULT_EARLY_EXIT_EN
    last_step = (step_q == SW'(STEPS - 1)) || (b_next == '0);
`else
    last_step = (step_q == SW'(STEPS - 1));
`endif

    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    acc_d     = acc_q;
    step_d    = step_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = {{WIDTH{1'b0}}, A};
          b_sh_d  = B;
          acc_d   = '0;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q << RADIX_BITS;
        b_sh_d = b_next;
        acc_d  = acc_sum;
        step_d = step_q + SW'(1);
        if (last_step) begin
          product_d = acc_sum;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      acc_q     <= '0;
      step_q    <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;

endmodule
